player_count_ctrl: RTL and testbench

//  Consumes the up/down/reset level outputs of the button-input stage.

---
 rtl/player_ctrl_pkg.sv | 16 +
 rtl/btn_sync_edge.sv | 29 ++
 rtl/player_count_ctrl.sv | 146 ++++++++++++++
 tb/tb_player_count_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/player_ctrl_pkg.sv
// Shared types and defaults for the player-count controller.
package player_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, HOLD_UP, HOLD_DN, LOCK} state_t;

  localparam int DEF_MIN_PLAYERS = 1;
  localparam int DEF_MAX_PLAYERS = 8;

  // Width of the auto-repeat hold timer: must hold the larger interval - 1.
  function automatic int rpt_w(input int delay, input int rate);
    int m;
    m = (delay > rate) ? delay : rate;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// One input synchroniser followed by a previous-value register for rise detect.
module btn_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise
);

  logic [STAGES-1:0] sr;
  logic              prev;

  // Shift the asynchronous level in; remember last synchronised value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr   <= '0;
      prev <= 1'b0;
    end else begin
      sr   <= {sr[STAGES-2:0], din};
      prev <= sr[STAGES-1];
    end
  end

  assign sync = sr[STAGES-1];
  assign rise = sync & ~prev;

endmodule

// File: rtl/player_count_ctrl.sv
// Saturating player counter driven by synchronised up/down/game_reset levels.
// Optional feature: define AUTO_REPEAT_EN to step repeatedly while a button is held.
module player_count_ctrl
  import player_ctrl_pkg::*;
#(
  parameter int MIN_PLAYERS  = DEF_MIN_PLAYERS,
  parameter int MAX_PLAYERS  = DEF_MAX_PLAYERS,
  parameter int CNT_W        = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up,
  input  logic             down,
  input  logic             game_reset,
  output logic [CNT_W-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             changed
);

  localparam logic [CNT_W-1:0] MINV = CNT_W'(MIN_PLAYERS);
  localparam logic [CNT_W-1:0] MAXV = CNT_W'(MAX_PLAYERS);

  if (MAX_PLAYERS <= MIN_PLAYERS || MAX_PLAYERS >= (2 ** CNT_W) || SYNC_STAGES < 2 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
    $error("player_count_ctrl: illegal parameter combination");
  end

  logic [2:0] sync_v, rise_v;

  btn_sync_edge #(.STAGES(SYNC_STAGES)) u_sync [2:0] (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({game_reset, down, up}),
    .sync (sync_v),
    .rise (rise_v)
  );

  wire up_s  = sync_v[0];
  wire dn_s  = sync_v[1];
  wire gr_s  = sync_v[2];
  wire up_r  = rise_v[0];
  wire dn_r  = rise_v[1];
  wire unused_gr_rise = rise_v[2];

  state_t state;
  logic   rpt_fire;
  logic   inc, dec;

`ifdef AUTO_REPEAT_EN
  localparam int TW = rpt_w(REPEAT_DELAY, REPEAT_RATE);
  logic [TW-1:0] timer;
  logic          rep;   // first (long) delay already served
  wire           holding = (state == HOLD_UP && up_s && !dn_r) ||
                           (state == HOLD_DN && dn_s && !up_r);

  assign rpt_fire = holding &&
                    (timer == (rep ? TW'(REPEAT_RATE - 1) : TW'(REPEAT_DELAY - 1)));

  // Hold timer: runs only while a hold continues, cleared otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n || gr_s || !holding) begin
      timer <= '0;
      rep   <= 1'b0;
    end else if (rpt_fire) begin
      timer <= '0;
      rep   <= 1'b1;
    end else begin
      timer <= timer + 1'b1;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // Step requests from fresh presses (IDLE) or repeat ticks (HOLD_*).
  always_comb begin
    inc = 1'b0;
    dec = 1'b0;
    if (!gr_s) begin
      case (state)
        IDLE:    begin inc = up_r & ~dn_r; dec = dn_r & ~up_r; end
        HOLD_UP: inc = rpt_fire;
        HOLD_DN: dec = rpt_fire;
        default: ;
      endcase
    end
  end

  wire [CNT_W-1:0] cnt_p1 = count + 1'b1;
  wire [CNT_W-1:0] cnt_m1 = count - 1'b1;

  // FSM, saturating count, registered flags and change pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= MINV;
      at_min  <= 1'b1;
      at_max  <= 1'b0;
      changed <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (gr_s) begin
        state <= LOCK;
        if (count != MINV) begin
          count   <= MINV;
          at_min  <= 1'b1;
          at_max  <= 1'b0;
          changed <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (up_r && dn_r) state <= LOCK;
            else if (up_r)    state <= HOLD_UP;
            else if (dn_r)    state <= HOLD_DN;
          end
          HOLD_UP: begin
            if (dn_r)       state <= LOCK;
            else if (!up_s) state <= IDLE;
          end
          HOLD_DN: begin
            if (up_r)       state <= LOCK;
            else if (!dn_s) state <= IDLE;
          end
          default: if (!up_s && !dn_s) state <= IDLE;
        endcase
        if (inc && count != MAXV) begin
          count   <= cnt_p1;
          at_max  <= (cnt_p1 == MAXV);
          at_min  <= 1'b0;
          changed <= 1'b1;
        end else if (dec && count != MINV) begin
          count   <= cnt_m1;
          at_min  <= (cnt_m1 == MINV);
          at_max  <= 1'b0;
          changed <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_player_count_ctrl.sv
// Randomised + directed bench for player_count_ctrl with a behavioural model.
module tb_player_count_ctrl;

  localparam int S    = 2;
  localparam int MINP = 1;
  localparam int MAXP = 8;
  localparam int CW   = 4;
  localparam int RD   = 10;
  localparam int RR   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          up = 1'b0, down = 1'b0, game_reset = 1'b0;
  logic [CW-1:0] count;
  logic          at_max, at_min, changed;

  int checks = 0;
  int errors = 0;

  player_count_ctrl #(
    .MIN_PLAYERS(MINP), .MAX_PLAYERS(MAXP), .CNT_W(CW), .SYNC_STAGES(S),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .up(up), .down(down), .game_reset(game_reset),
    .count(count), .at_max(at_max), .at_min(at_min), .changed(changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Inputs sampled per edge; the controller sees each level S edges late.
  bit q_up[$], q_dn[$], q_gr[$];
  int m_cnt  = MINP;
  bit m_chg  = 0;
  int m_mode = 0;      // 0 free, 1 up held, 2 down held, 3 locked
  int m_held = 0;      // edges a hold has continued past its press
  bit started = 0;

  function automatic bit seen(input bit q[$], input int back);
    int idx;
    idx = q.size() - back;
    return (idx >= 0) ? q[idx] : 1'b0;
  endfunction

  function automatic bit repeat_due(input int held);
`ifdef AUTO_REPEAT_EN
    return (held == RD) || (held > RD && ((held - RD) % RR) == 0);
`else
    return (held < 0);
`endif
  endfunction

  task automatic bump(input int dir);
    int n;
    n = m_cnt + dir;
    if (n >= MINP && n <= MAXP) begin
      m_cnt = n;
      m_chg = 1;
    end
  endtask

  always @(posedge clk) begin
    bit su, sd, gs, ru, rd;
    started = 1;
    if (!rst_n) begin
      m_cnt = MINP; m_chg = 0; m_mode = 0; m_held = 0;
      q_up.delete(); q_dn.delete(); q_gr.delete();
    end else begin
      su = seen(q_up, S); sd = seen(q_dn, S); gs = seen(q_gr, S);
      ru = su & ~seen(q_up, S + 1);
      rd = sd & ~seen(q_dn, S + 1);
      q_up.push_back(up); q_dn.push_back(down); q_gr.push_back(game_reset);
      if (q_up.size() > S + 1) begin
        void'(q_up.pop_front()); void'(q_dn.pop_front()); void'(q_gr.pop_front());
      end
      m_chg = 0;
      if (gs) begin
        if (m_cnt != MINP) begin m_cnt = MINP; m_chg = 1; end
        m_mode = 3;
      end else begin
        case (m_mode)
          0: if (ru && rd) m_mode = 3;
             else if (ru) begin m_mode = 1; m_held = 0; bump(1); end
             else if (rd) begin m_mode = 2; m_held = 0; bump(-1); end
          1: if (rd) m_mode = 3;
             else if (!su) m_mode = 0;
             else begin m_held++; if (repeat_due(m_held)) bump(1); end
          2: if (ru) m_mode = 3;
             else if (!sd) m_mode = 0;
             else begin m_held++; if (repeat_due(m_held)) bump(-1); end
          default: if (!su && !sd) m_mode = 0;
        endcase
      end
    end
  end

  int pulse_cnt = 0;

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("count", int'(count), m_cnt);
      chk("at_min", int'(at_min), int'(m_cnt == MINP));
      chk("at_max", int'(at_max), int'(m_cnt == MAXP));
      chk("changed", int'(changed), int'(m_chg));
      pulse_cnt += int'(changed);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit u, input bit d, input int hold, input int gap);
    @(negedge clk); up = u; down = d;
    cyc(hold);
    up = 0; down = 0;
    cyc(gap);
  endtask

  initial begin
    int kind;
    // 1: reset
    cyc(1); rst_n = 1; cyc(1);
    chk("rst_count", int'(count), 1);
    chk("rst_at_min", int'(at_min), 1);
    chk("rst_at_max", int'(at_max), 0);
    chk("rst_changed", int'(changed), 0);

    // 2: latency of a single press
    up = 1;                         // first sampled at next edge E0
    for (int i = 0; i < S; i++) begin
      cyc(1); chk("lat_before", int'(count), 1);
    end
    cyc(1);
    chk("lat_count", int'(count), 2);
    chk("lat_changed", int'(changed), 1);
    cyc(1);
    chk("lat_changed_drop", int'(changed), 0);
    up = 0; cyc(6);

    // 3: saturation at both ends
    for (int i = 0; i < 6; i++) press(1, 0, 3, 4);
    chk("sat_top", int'(count), 8);
    chk("sat_top_flag", int'(at_max), 1);
    pulse_cnt = 0;
    press(1, 0, 3, 6);
    chk("sat_top_hold", int'(count), 8);
    chk("sat_top_nopulse", pulse_cnt, 0);
    for (int i = 0; i < 8; i++) press(0, 1, 3, 4);
    chk("sat_bot", int'(count), 1);
    chk("sat_bot_flag", int'(at_min), 1);

    // 4: simultaneous press locks
    @(negedge clk); up = 1; down = 1;
    cyc(S + 4); chk("lock_both", int'(count), 1);
    up = 0; cyc(4); up = 1; cyc(S + 4);
    chk("lock_still", int'(count), 1);
    up = 0; down = 0; cyc(5);
    press(1, 0, 3, 5);
    chk("lock_exit", int'(count), 2);

    // 5: game reset mid-hold
    for (int i = 0; i < 3; i++) press(1, 0, 3, 4);
    chk("gr_pre", int'(count), 5);
    @(negedge clk); up = 1; cyc(8);
    pulse_cnt = 0;
    game_reset = 1; cyc(8);
    chk("gr_count", int'(count), 1);
    chk("gr_one_pulse", pulse_cnt, 1);
    game_reset = 0; cyc(10);
    chk("gr_held_up", int'(count), 1);
    up = 0; cyc(5);
    press(1, 0, 3, 5);
    chk("gr_resume", int'(count), 2);

    // 6: long hold (auto-repeat when enabled)
    @(negedge clk); game_reset = 1; cyc(4); game_reset = 0; cyc(5);
    @(negedge clk); up = 1; cyc(60);
`ifdef AUTO_REPEAT_EN
    chk("long_hold", int'(count), 8);
`else
    chk("long_hold", int'(count), 2);
`endif
    up = 0; cyc(5);

    // random traffic
    for (int it = 0; it < 400; it++) begin
      kind = int'($urandom_range(0, 19));
      if (kind < 8)       press(1, 0, int'($urandom_range(1, 25)), int'($urandom_range(0, 8)));
      else if (kind < 16) press(0, 1, int'($urandom_range(1, 25)), int'($urandom_range(0, 8)));
      else if (kind < 17) press(1, 1, int'($urandom_range(1, 10)), int'($urandom_range(0, 8)));
      else if (kind < 18) begin
        @(negedge clk); up = 1'($urandom_range(0, 1)); down = 1'($urandom_range(0, 1));
        cyc(int'($urandom_range(1, 6))); game_reset = 1;
        cyc(int'($urandom_range(1, 6))); game_reset = 0;
        cyc(int'($urandom_range(0, 6))); up = 0; down = 0; cyc(3);
      end else if (kind < 19) begin
        @(negedge clk); up = 1; cyc(int'($urandom_range(1, 5)));
        down = 1; cyc(int'($urandom_range(1, 5)));
        up = 0; down = 0; cyc(int'($urandom_range(0, 6)));
      end else begin
        @(negedge clk); rst_n = 0; cyc(1); rst_n = 1; cyc(2);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
